// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM states,
// requester IDs and parameter defaults.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_t;

    localparam int          DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the arbiter: master is the arbiter, slave is the memory.
interface mem_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_ARB_ROUND_ROBIN_EN: ties alternate using the parent's last-grant pointer.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic    if_req,
    input  logic    d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  req_id_t last,
`endif
    output logic    valid,
    output req_id_t grant
);

    always_comb begin
        valid = if_req | d_req;
        grant = REQ_D;
        if (if_req && !d_req) begin
            grant = REQ_IF;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        else if (if_req && d_req && (last == REQ_D)) begin
            grant = REQ_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one multi-cycle memory port between instruction fetch and data.
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin tie-break instead of data-first.
//
//   state      | meaning
//   -----------+----------------------------------------------
//   ST_IDLE    | no transaction; grant on any request
//   ST_BUSY_IF | fetch access on the bus, waiting for mem_ack
//   ST_BUSY_D  | load/store access on the bus, waiting for mem_ack
//   ST_DONE    | ready pulse to winner; no grant this cycle
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [31:0]          if_addr,
    output logic [31:0]          if_rdata,
    output logic                 if_ready,
    input  logic                 d_rd_req,
    input  logic                 d_wr_req,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_ready,
    mem_arbiter_if.master        mem,
    output logic                 stall_b,
    output logic                 err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    req_id_t     win;
    req_id_t     grant;
    logic        grant_valid;
    logic        do_grant, do_ack, do_tmo;
    logic        busy;
    logic [7:0]  cnt;
    logic        mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t last_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= REQ_IF;
        end else if (do_grant) begin
            last_grant <= grant;
        end
    end
`endif

    mem_arb_pick u_pick (
        .if_req (if_req),
        .d_req  (d_rd_req | d_wr_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last   (last_grant),
`endif
        .valid  (grant_valid),
        .grant  (grant)
    );

    assign busy = (state == ST_BUSY_IF) || (state == ST_BUSY_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_ack    = 1'b0;
        do_tmo    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    do_grant  = 1'b1;
                    state_nxt = (grant == REQ_D) ? ST_BUSY_D : ST_BUSY_IF;
                end
            end
            ST_BUSY_IF, ST_BUSY_D: begin
                if (mem.mem_ack) begin
                    do_ack    = 1'b1;
                    state_nxt = ST_DONE;
                end else if (cnt == TMO_LAST) begin
                    do_tmo    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win         <= REQ_IF;
            cnt         <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            err         <= 1'b0;
        end else begin
            if (do_grant) begin
                win        <= grant;
                cnt        <= '0;
                mem_addr_q <= (grant == REQ_D) ? d_addr : if_addr;
                // A simultaneous load+store request is serviced as a store.
                mem_we_q   <= (grant == REQ_D) && d_wr_req;
                if (grant == REQ_D) begin
                    mem_wdata_q <= d_wdata;
                end
            end else if (busy && !mem.mem_ack) begin
                cnt <= cnt + 8'd1;
            end

            if (do_ack) begin
                if (win == REQ_IF) begin
                    if_rdata <= mem.mem_rdata;
                end else if (!mem_we_q) begin
                    d_rdata <= mem.mem_rdata;
                end
            end

            if (do_tmo) begin
                err <= 1'b1;
                if (win == REQ_IF) begin
                    if_rdata <= ERR_DATA;
                end else begin
                    d_rdata <= ERR_DATA;
                end
            end
        end
    end

    assign mem.mem_req   = busy;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign if_ready = (state == ST_DONE) && (win == REQ_IF);
    assign d_ready  = (state == ST_DONE) && (win == REQ_D);

    assign stall_b = rst | ~((if_req & ~if_ready) | ((d_rd_req | d_wr_req) & ~d_ready));

endmodule
